// File: rtl/pwm_pr_pkg.sv
// Shared types and helpers for the pwm_pr dithered PWM stage.
// Holds the duty-handshake state encoding, legal width range and the duty clamp.
package pwm_pr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 8;

   // Duty words above one full period (2^width codes) saturate to a full period.
   function automatic int unsigned sat_duty(input int unsigned duty, input int unsigned width);
      int unsigned full;
      full = 32'd1 << width;
      return (duty > full) ? full : duty;
   endfunction

endpackage

// File: rtl/pwm_pr_hs.sv
// Single-entry duty holding register for pwm_pr: valid/ready intake, clamp,
// and the boundary mux that produces the effective duty for the current edge.
module pwm_pr_hs
   import pwm_pr_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter int unsigned SYNC  = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inc,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH:0] duty,
   input  logic           duty_vld,
   input  logic [WIDTH:0] act,
   output logic           duty_rdy,
   output logic [WIDTH:0] deff,
   output logic           bnd
);

   state_t         state;
   state_t         state_nxt;
   logic [WIDTH:0] pend;
   logic [WIDTH:0] duty_sat;
   logic           accept;
   logic           load;

   assign duty_sat = (WIDTH+1)'(sat_duty(32'(duty), WIDTH));
   assign bnd      = inc && (cnt == WIDTH'(SYNC));
   assign accept   = duty_vld && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !bnd) state_nxt = PEND;
         PEND:    if (bnd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A word accepted on the boundary edge itself bypasses the holding register.
   always_comb begin
      duty_rdy = (state == IDLE);
      load     = 1'b0;
      deff     = act;
      case (state)
         IDLE: begin
            load = accept && !bnd;
            if (bnd && accept) deff = duty_sat;
         end
         PEND: begin
            if (bnd) deff = pend;
         end
         default: begin
            load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else if (load) begin
         pend <= duty_sat;
      end
   end

endmodule

// File: rtl/pwm_pr.sv
// Dithered PWM / pulse-density stage comparing a pseudo-random counter against a duty word.
// Optional macro PWM_PR_PSTB_EN adds the registered period strobe output pstb.
module pwm_pr
   import pwm_pr_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter int unsigned SYNC     = 0,
   parameter int unsigned DUTY_RST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH:0]   duty,
   input  logic             duty_vld,
   output logic             duty_rdy,
`ifdef PWM_PR_PSTB_EN
   output logic             pstb,
`endif
   output logic             out,
   output logic [WIDTH:0]   act
);

   localparam logic [WIDTH:0] ACT_RST = (WIDTH+1)'(sat_duty(DUTY_RST, WIDTH));

   logic [WIDTH:0] deff;
   logic           bnd;

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("pwm_pr: WIDTH must be within 4..8");
   end

   pwm_pr_hs #(
      .WIDTH (WIDTH),
      .SYNC  (SYNC)
   ) u_hs (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc),
      .cnt      (cnt),
      .duty     (duty),
      .duty_vld (duty_vld),
      .act      (act),
      .duty_rdy (duty_rdy),
      .deff     (deff),
      .bnd      (bnd)
   );

   // The compare is done one bit wider than the counter so deff == 2^WIDTH is always high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= 1'b0;
         act <= ACT_RST;
      end else begin
         if (inc) out <= ({1'b0, cnt} < deff);
         if (bnd) act <= deff;
      end
   end

`ifdef PWM_PR_PSTB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pstb <= 1'b0;
      end else begin
         pstb <= bnd;
      end
   end
`endif

endmodule

// File: tb/tb_pwm_pr.sv
// Self-checking bench for pwm_pr (WIDTH=4, SYNC=0): random and directed stimulus
// compared against a behavioural model of the duty handshake and period compare.
module tb_pwm_pr;

   localparam int WIDTH  = 4;
   localparam int PERIOD = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inc;
   logic [3:0] cnt;
   logic [4:0] duty;
   logic       duty_vld;
   logic       duty_rdy;
   logic       out;
   logic [4:0] act;
`ifdef PWM_PR_PSTB_EN
   logic       pstb;
`endif

   int checks = 0;
   int errors = 0;

   int act_m;
   int out_m;
   int pstb_m;
   int pend_q[$];

   int perm[16] = '{0, 7, 12, 3, 9, 14, 1, 5, 11, 2, 15, 8, 4, 13, 6, 10};
   int pos;
   int obs_out;

   always #5 clk = ~clk;

   pwm_pr #(
      .WIDTH    (WIDTH),
      .SYNC     (0),
      .DUTY_RST (0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc),
      .cnt      (cnt),
      .duty     (duty),
      .duty_vld (duty_vld),
      .duty_rdy (duty_rdy),
`ifdef PWM_PR_PSTB_EN
      .pstb     (pstb),
`endif
      .out      (out),
      .act      (act)
   );

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      act_m  = 0;
      out_m  = 0;
      pstb_m = 0;
      pend_q.delete();
   endtask

   // One rising edge of the reference: period boundary, one-deep pending word, compare.
   task automatic modelEdge(input int i_inc, input int i_cnt, input int i_duty, input int i_vld);
      bit accepted;
      bit boundary;
      int dsat;
      accepted = (i_vld != 0) && (pend_q.size() == 0);
      boundary = (i_inc != 0) && (i_cnt == 0);
      dsat     = (i_duty > PERIOD) ? PERIOD : i_duty;
      if (boundary) begin
         if (pend_q.size() > 0) act_m = pend_q.pop_front();
         else if (accepted) act_m = dsat;
      end else if (accepted) begin
         pend_q.push_back(dsat);
      end
      if (i_inc != 0) out_m = (i_cnt < act_m) ? 1 : 0;
      pstb_m = boundary ? 1 : 0;
   endtask

   // Check what the previous edge produced, then present the next inputs.
   task automatic applyStimulus(input int i_inc, input int i_cnt, input int i_duty, input int i_vld);
      @(negedge clk);
      checkOutput("out", int'(out), out_m);
      checkOutput("act", int'(act), act_m);
`ifdef PWM_PR_PSTB_EN
      checkOutput("pstb", int'(pstb), pstb_m);
`endif
      obs_out  = int'(out);
      inc      = (i_inc != 0);
      cnt      = 4'(i_cnt);
      duty     = 5'(i_duty);
      duty_vld = (i_vld != 0);
      checkOutput("duty_rdy", int'(duty_rdy), (pend_q.size() == 0) ? 1 : 0);
      modelEdge(i_inc, i_cnt, i_duty, i_vld);
   endtask

   task automatic stepWalk(input int i_inc, input int i_duty, input int i_vld);
      applyStimulus(i_inc, perm[pos], i_duty, i_vld);
      if (i_inc != 0) pos = (pos + 1) % PERIOD;
   endtask

   task automatic walkToBoundary();
      while (pos != 0) stepWalk(1, 0, 0);
   endtask

   // Count highs over the inc edges starting at the next boundary edge.
   task automatic measure(input int edges, input int exp_hi, input string tag);
      int hi;
      hi = 0;
      walkToBoundary();
      stepWalk(1, 0, 0);
      for (int i = 0; i < edges; i++) begin
         stepWalk(1, 0, 0);
         hi += obs_out;
      end
      checkOutput(tag, hi, exp_hi);
   endtask

   initial begin
      rst_n    = 1'b0;
      inc      = 1'b0;
      cnt      = '0;
      duty     = '0;
      duty_vld = 1'b0;
      pos      = 0;
      modelReset();

      #2;
      checkOutput("rst_out", int'(out), 0);
      checkOutput("rst_act", int'(act), 0);
      checkOutput("rst_rdy", int'(duty_rdy), 1);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] random phase");
      for (int i = 0; i < 400; i++) begin
         stepWalk(($urandom_range(0, 9) < 8) ? 1 : 0,
                  int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0);
      end

      $display("[TB] duty count");
      while (pend_q.size() != 0) stepWalk(1, 0, 0);
      if (pos == 0) stepWalk(1, 0, 0);
      stepWalk(1, 5, 1);
      measure(16, 5, "hi_count_d5");

      $display("[TB] extremes");
      stepWalk(1, 0, 1);
      measure(32, 0, "hi_count_d0");
      stepWalk(1, 16, 1);
      measure(32, 32, "hi_count_d16");
      stepWalk(1, 31, 1);
      walkToBoundary();
      stepWalk(1, 0, 0);
      stepWalk(1, 0, 0);
      checkOutput("act_clamp", int'(act), 16);

      $display("[TB] handshake");
      stepWalk(1, 3, 1);
      for (int i = 0; i < 3; i++) stepWalk(1, 7, 1);
      checkOutput("rdy_pend", int'(duty_rdy), 0);
      walkToBoundary();
      stepWalk(1, 7, 1);
      stepWalk(1, 7, 1);
      checkOutput("act_hs", int'(act), 3);
      checkOutput("rdy_after_bnd", int'(duty_rdy), 1);
      stepWalk(1, 0, 0);
      checkOutput("rdy_second", int'(duty_rdy), 0);

      $display("[TB] bypass and stall");
      walkToBoundary();
      stepWalk(1, 0, 0);
      walkToBoundary();
      stepWalk(1, 9, 1);
      stepWalk(1, 0, 0);
      checkOutput("act_bypass", int'(act), 9);
      for (int i = 0; i < 4; i++) stepWalk(1, 0, 0);
      stepWalk(0, 11, 1);
      for (int i = 0; i < 9; i++) stepWalk(0, 0, 0);
      checkOutput("act_stall", int'(act), 9);
      measure(16, 11, "hi_count_d11");

      $display("[TB] reset mid-period with pending word");
      stepWalk(1, 6, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_out", int'(out), 0);
      checkOutput("arst_act", int'(act), 0);
      checkOutput("arst_rdy", int'(duty_rdy), 1);
      modelReset();
      pos = 0;
      @(negedge clk);
      inc      = 1'b0;
      duty_vld = 1'b0;
      rst_n    = 1'b1;
      measure(16, 0, "hi_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_pr.md
Name: pwm_pr

Overview:
- Dithered PWM / pulse-density stage sitting directly downstream of a ctr_pr4..ctr_pr8 pseudo-random counter.
- Compares the counter's scrambled output against a duty word, producing a 1-bit output.
- Per period, the output is high for exactly `duty` counter codes, spread pseudo-randomly rather than as one block.
- Duty updates arrive via valid/ready handshake and take effect only at a period boundary, so no period is ever mixed.

Parameters:
- WIDTH, 8, counter width; legal 4..8 (matches ctr_pr4..ctr_pr8).
- SYNC, 0, counter code marking the period boundary.
- DUTY_RST, 0, duty value active after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- inc  in  1  advance strobe; the same signal drives the upstream counter's inc.
- cnt  in  WIDTH  upstream counter output.
- duty  in  WIDTH+1  requested duty, 0..2^WIDTH.
- duty_vld  in  1  duty word valid.
- duty_rdy  out  1  stage can accept a duty word.
- out  out  1  PWM/PDM output, registered.
- act  out  WIDTH+1  currently active duty, registered.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, act=DUTY_RST, pending register cleared, state=IDLE, duty_rdy=1.
- Reset may assert mid-period; the pending word is discarded.
- Release is synchronous to clk with no extra latency; the first evaluating edge is the first edge with inc=1.
- Clamp: any duty > 2^WIDTH is captured as 2^WIDTH.
- States:
  - IDLE: no pending word; duty_rdy=1.
  - PEND: one word held; duty_rdy=0.
- Accept: duty_vld && duty_rdy at an edge.
  - In IDLE with no boundary, capture the word and go to PEND.
- Boundary: inc && cnt==SYNC at an edge.
  - PEND: act <= pending, go to IDLE.
  - IDLE with accept in the same edge: act <= the incoming duty directly (bypass), stay IDLE.
  - IDLE without accept: act unchanged.
- Effective duty (deff) is the value act takes at this edge.
- Compare, only on edges with inc=1: out <= (cnt < deff), unsigned, evaluated at WIDTH+1 bits.
  - deff=0: out constantly 0.
  - deff=2^WIDTH: out constantly 1.
- inc=0: out, act and state hold; accept is still allowed in IDLE.
- Latency: out reflects the cnt present at the previous inc edge (1 cycle).
  - A newly accepted duty affects out starting at the first boundary edge after acceptance, which may be the acceptance edge itself.
- High count: over any full period (2^WIDTH inc edges, each code once), out is high for exactly deff edges.
- cnt not visiting SYNC: a pending word stays pending indefinitely (duty_rdy held low). This is legal, not an error.
- duty_vld may drop without acceptance; no requirement on the source to hold.

Optional Feature:
- Macro: PWM_PR_PSTB_EN.
- Defined: adds output pstb (1 bit, registered, reset 0), pulsing high for one clk after every boundary edge, whether or not act changed. Lets downstream logic or the bench frame periods.
- Undefined: port absent; no boundary register beyond the one needed for the act update.

Decomposition:
- Shared package pwm_pr_pkg holds:
  - State encoding (IDLE=0, PEND=1).
  - WIDTH_MIN=4 and WIDTH_MAX=8.
  - Clamp function sat_duty(WIDTH).
- One sub-module, pwm_pr_hs: the single-entry duty holding register with valid/ready, clamp and bypass mux.
  - Outputs deff and the boundary flag to the top.
  - Top owns the comparator and the out/act/pstb registers.

Test Plan:
- Reset: WIDTH=4, DUTY_RST=0, rst_n low mid-run with duty pending → out=0, act=0, duty_rdy=1 immediately (before the next clk edge).
- Duty count: WIDTH=4, cnt driven through a fixed 16-code permutation, inc=1, duty=5 accepted before the boundary → from the next boundary, out is high exactly 5 of every 16 edges, matching the codes <5.
- Extremes: duty=0 → out 0 for 32 edges; duty=16 → out 1 for 32 edges; duty=31 → captured as 16, act=16.
- Handshake: accept 3 mid-period → duty_rdy=0 until boundary, act=3 at boundary edge, duty_rdy=1 next cycle. A second vld held during PEND → not accepted until duty_rdy=1.
- Bypass/stall: accept 9 on the exact boundary edge in IDLE → act=9 that edge. inc=0 for 10 cycles mid-period → out and act frozen; the period completes 16 inc edges later.
- PWM_PR_PSTB_EN defined: pstb pulses once per 16 inc edges, one cycle after cnt==SYNC. Undefined: the build has no pstb port.
